pwm_capture: RTL

- Receive-side counterpart of the team's PWM generator: measures an incoming PWM waveform and recovers its high time and period as cycle counts in the local clock domain.
- Feeds status/telemetry logic that needs the duty value a remote or looped-back PWM source is producing.
- Input is synchronized, edge-detected, then measured per rising-edge-to-rising-edge frame; results are published with a one-cycle valid strobe.

---
 rtl/pwm_capture.sv | 106 ++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// Measures an incoming PWM waveform: high time and period of each rising-edge
// frame in local clock cycles, with saturation-based stuck-level detection.
module pwm_capture #(
  parameter int WIDTH       = 23,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] high_time,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  typedef enum logic {ARM, MEAS} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s, s_d;
  logic                   rise, fall, sat_hit;
  logic [WIDTH-1:0]       per_cnt, hi_cnt, hi_lat;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      s_d  <= sync[SYNC_STAGES-1];
    end
  end

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;
  // A saturation publishes once; the stuck flags suppress repeats until re-armed.
  assign sat_hit = (per_cnt == CNT_MAX) && !(stuck_high || stuck_low);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARM;
    else          state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    if (!enable)      state_nxt = ARM;
    else if (rise)    state_nxt = MEAS;
    else if (sat_hit) state_nxt = ARM;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt    <= '0;
      hi_cnt     <= '0;
      hi_lat     <= '0;
      high_time  <= '0;
      period     <= '0;
      valid      <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        per_cnt    <= '0;
        hi_cnt     <= '0;
        hi_lat     <= '0;
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end else if (rise) begin
        // Only a rise that closes a measured frame publishes; in ARM it just arms.
        if (state == MEAS) begin
          high_time <= hi_lat;
          period    <= per_cnt;
          valid     <= 1'b1;
        end
        per_cnt    <= CNT_ONE;
        hi_cnt     <= CNT_ONE;
        hi_lat     <= '0;
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end else if (sat_hit) begin
        period     <= CNT_MAX;
        high_time  <= s ? CNT_MAX : '0;
        valid      <= 1'b1;
        stuck_high <= s;
        stuck_low  <= ~s;
      end else begin
        if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_ONE;
        if (state == MEAS) begin
          if (s && hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + CNT_ONE;
          if (fall) hi_lat <= hi_cnt;
        end
      end
    end
  end

endmodule
